// File: rtl/fp_operand_loader.sv
// Byte-serial operand collector for the FP ALU: opcode, operand A, operand B (one byte per beat).
// Define FP_LOADER_CSUM_EN to append an XOR checksum byte that must match before issue.
module fp_operand_loader #(
  parameter int         TIMEOUT    = 1024,
  parameter logic [7:0] UNARY_MASK = 8'b0100_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        start,
  input  logic [2:0]  opcode_in,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [2:0]  op_code,
  output logic        op_valid,
  input  logic        op_ready,
  output logic        busy,
  output logic [1:0]  byte_cnt,
  output logic        err
);

  localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
`ifdef FP_LOADER_CSUM_EN
    CSUM,
`endif
    ISSUE
  } state_t;

`ifdef FP_LOADER_CSUM_EN
  localparam state_t AFTER_OPS = CSUM;
`else
  localparam state_t AFTER_OPS = ISSUE;
`endif

  state_t        state_q, state_d;
  logic [31:0]   op_a_q, op_a_d;
  logic [31:0]   op_b_q, op_b_d;
  logic [2:0]    op_code_q, op_code_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          restart;
  logic          loading;
  logic          tmo_hit;
  logic          last_byte;

  // Start restarts from any state except ISSUE, where the pair is already committed.
  assign restart   = start && (state_q != ISSUE);
  assign tmo_hit   = (TIMEOUT != 0) && (tmo_q == TMO_LAST);
  assign last_byte = (byte_cnt_q == 2'd3);

`ifdef FP_LOADER_CSUM_EN
  logic [7:0] csum_q, csum_d;
  logic       csum_ok;

  always_comb begin
    csum_d = csum_q;
    if (restart) begin
      csum_d = {5'b0, opcode_in};
    end else if (in_valid && ((state_q == LOAD_A) || (state_q == LOAD_B))) begin
      csum_d = csum_q ^ in_byte;
    end
  end

  assign csum_ok = (in_byte == csum_q);
  assign loading = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == CSUM);
`else
  assign loading = (state_q == LOAD_A) || (state_q == LOAD_B);
`endif

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_code_d  = op_code_q;
    byte_cnt_d = byte_cnt_q;
    tmo_d      = tmo_q;
    err_d      = 1'b0;

    if (restart) begin
      state_d    = LOAD_A;
      op_code_d  = opcode_in;
      op_a_d     = '0;
      op_b_d     = '0;
      byte_cnt_d = '0;
      tmo_d      = '0;
    end else if (state_q == ISSUE) begin
      // Operands stay frozen; a stray byte here is an overrun.
      err_d = in_valid;
      if (op_ready) begin
        state_d = IDLE;
      end
    end else if (loading) begin
      if (in_valid) begin
        tmo_d = '0;
        if (state_q == LOAD_A) begin
          op_a_d     = {op_a_q[23:0], in_byte};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (last_byte) begin
            state_d = UNARY_MASK[op_code_q] ? AFTER_OPS : LOAD_B;
          end
        end else if (state_q == LOAD_B) begin
          op_b_d     = {op_b_q[23:0], in_byte};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (last_byte) begin
            state_d = AFTER_OPS;
          end
        end
`ifdef FP_LOADER_CSUM_EN
        else begin
          if (csum_ok) begin
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
`endif
      end else if (tmo_hit) begin
        state_d    = IDLE;
        err_d      = 1'b1;
        byte_cnt_d = '0;
        tmo_d      = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_code_q  <= '0;
      byte_cnt_q <= '0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_code_q  <= op_code_d;
      byte_cnt_q <= byte_cnt_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
    end
  end

`ifdef FP_LOADER_CSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_code  = op_code_q;
  assign op_valid = (state_q == ISSUE);
  assign busy     = (state_q != IDLE);
  assign byte_cnt = byte_cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_fp_operand_loader.sv
// Directed bench for fp_operand_loader: a byte-count reference model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_fp_operand_loader;

  localparam int         TMO   = 16;
  localparam logic [7:0] UMASK = 8'b0100_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        start;
  logic [2:0]  opcode_in;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [2:0]  op_code;
  logic        op_valid;
  logic        op_ready;
  logic        busy;
  logic [1:0]  byte_cnt;
  logic        err;

  int total = 0;
  int bad = 0;
  int err_count = 0;
  logic chk_en = 1'b0;

  fp_operand_loader #(.TIMEOUT(TMO), .UNARY_MASK(UMASK)) dut (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .start(start),
    .opcode_in(opcode_in), .op_a(op_a), .op_b(op_b), .op_code(op_code),
    .op_valid(op_valid), .op_ready(op_ready), .busy(busy), .byte_cnt(byte_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // Reference: counts accepted bytes per operation rather than tracking named states.
  typedef struct packed {
    logic        active;
    logic        issue;
    logic        err;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] n;
    logic [31:0] need;
    logic [31:0] idle;
    logic [7:0]  x;
  } model_t;

  model_t m = '0;

  function automatic model_t model_next(input model_t cur, input logic r_i, input logic st_i,
                                        input logic [2:0] opc, input logic iv,
                                        input logic [7:0] ib, input logic rdy);
    model_t r = cur;
    r.err = 1'b0;
    if (r_i) begin
      r = '0;
    end else if (cur.issue) begin
      if (iv) r.err = 1'b1;
      if (rdy) r.issue = 1'b0;
    end else if (st_i) begin
      r.active = 1'b1;
      r.op     = opc;
      r.a      = '0;
      r.b      = '0;
      r.n      = 0;
      r.need   = UMASK[opc] ? 4 : 8;
      r.idle   = 0;
      r.x      = {5'b0, opc};
    end else if (cur.active) begin
      if (iv) begin
        r.idle = 0;
        if (cur.n < cur.need) begin
          if (cur.n < 4) r.a = (cur.a << 8) | {24'b0, ib};
          else           r.b = (cur.b << 8) | {24'b0, ib};
          r.x = cur.x ^ ib;
          r.n = cur.n + 1;
`ifndef FP_LOADER_CSUM_EN
          if (r.n == cur.need) begin
            r.active = 1'b0;
            r.issue  = 1'b1;
          end
`endif
        end else begin
          r.active = 1'b0;
          if (ib == cur.x) r.issue = 1'b1;
          else             r.err   = 1'b1;
        end
      end else begin
        r.idle = cur.idle + 1;
        if (r.idle == TMO) begin
          r.active = 1'b0;
          r.err    = 1'b1;
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    m <= model_next(m, rst, start, opcode_in, in_valid, in_byte, op_ready);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("op_valid", {31'b0, op_valid}, {31'b0, m.issue});
      check("busy", {31'b0, busy}, {31'b0, m.active | m.issue});
      check("err", {31'b0, err}, {31'b0, m.err});
      check("byte_cnt", {30'b0, byte_cnt},
            (m.active && (m.n < m.need)) ? {30'b0, m.n[1:0]} : 32'd0);
      check("op_a", op_a, m.a);
      check("op_b", op_b, m.b);
      check("op_code", {29'b0, op_code}, {29'b0, m.op});
      if (err === 1'b1) err_count++;
      if (op_valid === 1'b1 && op_ready === 1'b1)
        $display("issue: op=%0d a=%h b=%h", op_code, op_a, op_b);
    end
  end

  task automatic send_start(input logic [2:0] op);
    start = 1'b1;
    opcode_in = op;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [2:0] op, input logic [7:0] b [8], input int n, input int gap);
    logic [7:0] x;
    x = {5'b0, op};
    send_start(op);
    for (int i = 0; i < n; i++) begin
      send_byte(b[i]);
      x = x ^ b[i];
      repeat (gap) @(negedge clk);
    end
`ifdef FP_LOADER_CSUM_EN
    send_byte(x);
`endif
  endtask

  logic [7:0] t1 [8];
  logic [7:0] t3 [8];
  logic [7:0] t4 [8];
  int e0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    t1 = '{8'h3F, 8'h80, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00};
    t3 = '{8'hC0, 8'h49, 8'h0F, 8'hDB, 8'h00, 8'h00, 8'h00, 8'h00};
    t4 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    rst = 1'b1; in_byte = '0; in_valid = 1'b0; start = 1'b0; opcode_in = '0; op_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_valid", {31'b0, op_valid}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_a", op_a, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: binary op, immediate acceptance
    load(3'd0, t1, 8, 0);
    check("t1_valid", {31'b0, op_valid}, 32'd1);
    check("t1_a", op_a, 32'h3F80_0000);
    check("t1_b", op_b, 32'h4000_0000);
    check("t1_code", {29'b0, op_code}, 32'd0);
    @(negedge clk);
    check("t1_drop", {31'b0, op_valid}, 32'd0);

    // 2: five cycles of backpressure, handshake on the sixth
    op_ready = 1'b0;
    load(3'd0, t1, 8, 0);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", {31'b0, op_valid}, 32'd1);
      check("t2_hold_a", op_a, 32'h3F80_0000);
      @(negedge clk);
    end
    op_ready = 1'b1;
    check("t2_c6_valid", {31'b0, op_valid}, 32'd1);
    @(negedge clk);
    check("t2_done", {31'b0, op_valid}, 32'd0);

    // 3: unary opcode skips operand B
    load(3'd6, t3, 4, 0);
    check("t3_valid", {31'b0, op_valid}, 32'd1);
    check("t3_a", op_a, 32'hC049_0FDB);
    check("t3_b", op_b, 32'd0);
    @(negedge clk);

    // 4: restart mid-load, then start with a simultaneous byte in IDLE
    e0 = err_count;
    send_start(3'd2);
    send_byte(8'hAA);
    send_byte(8'hBB);
    load(3'd1, t4, 8, 0);
    check("t4_code", {29'b0, op_code}, 32'd1);
    check("t4_a", op_a, 32'h1122_3344);
    check("t4_b", op_b, 32'h5566_7788);
    @(negedge clk);
    start = 1'b1; opcode_in = 3'd3; in_valid = 1'b1; in_byte = 8'hEE;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(t4[i]);
`ifdef FP_LOADER_CSUM_EN
    send_byte(8'h03 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'h55 ^ 8'h66 ^ 8'h77 ^ 8'h88);
`endif
    check("t4_start_wins_a", op_a, 32'h1122_3344);
    check("t4_no_err", err_count, e0);
    @(negedge clk);

    // 5: timeout boundary, spaced bytes, overrun and ignored start in ISSUE
    send_start(3'd0);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    repeat (15) @(negedge clk);
    check("t5_busy_15", {31'b0, busy}, 32'd1);
    check("t5_err_15", {31'b0, err}, 32'd0);
    @(negedge clk);
    check("t5_tmo_err", {31'b0, err}, 32'd1);
    check("t5_tmo_busy", {31'b0, busy}, 32'd0);
    check("t5_tmo_valid", {31'b0, op_valid}, 32'd0);
    @(negedge clk);
    load(3'd0, t1, 8, 10);
    check("t5_gap_a", op_a, 32'h3F80_0000);
    @(negedge clk);
    op_ready = 1'b0;
    load(3'd0, t1, 8, 0);
    send_byte(8'hAA);
    check("t5_ovr_err", {31'b0, err}, 32'd1);
    check("t5_ovr_a", op_a, 32'h3F80_0000);
    send_start(3'd5);
    check("t5_issue_start", {29'b0, op_code}, 32'd0);
    repeat (20) @(negedge clk);
    check("t5_no_issue_tmo", {31'b0, op_valid}, 32'd1);
    op_ready = 1'b1;
    @(negedge clk);
    check("t5_release", {31'b0, op_valid}, 32'd0);

`ifdef FP_LOADER_CSUM_EN
    // 6: checksum mismatch
    send_start(3'd0);
    for (int i = 0; i < 8; i++) send_byte(t1[i]);
    send_byte(8'h00);
    check("t6_bad_err", {31'b0, err}, 32'd1);
    check("t6_bad_valid", {31'b0, op_valid}, 32'd0);
    @(negedge clk);
`endif

    // reset while loading operand B
    send_start(3'd3);
    for (int i = 0; i < 6; i++) send_byte(t4[i]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_a", op_a, 32'd0);
    check("rst_b", op_b, 32'd0);
    check("rst_code", {29'b0, op_code}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_cnt", {30'b0, byte_cnt}, 32'd0);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
